bitstream_aligner: RTL

BITSTREAM_ALIGNER -- requirements
Module: bitstream_aligner

---
 rtl/rice_pkg.sv | 21 ++
 rtl/leftrotor.sv | 24 ++
 rtl/bitstream_aligner.sv | 117 +++++++++++
 3 files changed

// File: rtl/rice_pkg.sv
// Shared constants and types for the Rice bitstream front end.
// Word, pointer and consume-count widths plus the aligner occupancy states.
package rice_pkg;

    localparam int WORD_W = 64;
    localparam int PTR_W  = 6;
    localparam int CONS_W = 7;

    // Encoding doubles as the buffered-word count driven on the level port.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } aligner_state_e;

    // A consume request is well-formed only for 1..WORD_W bits.
    function automatic logic cons_bits_legal(input logic [CONS_W-1:0] bits);
        return (bits != '0) && (bits <= CONS_W'(WORD_W));
    endfunction

endpackage

// File: rtl/leftrotor.sv
// 64-bit combinational left rotator built as a 6-stage logarithmic barrel.
// Stage k rotates by 2**k when shamt[k] is set.
module leftrotor
    import rice_pkg::*;
(
    input  logic [WORD_W-1:0] in_word,
    input  logic [PTR_W-1:0]  shamt,
    output logic [WORD_W-1:0] out_word
);

    logic [PTR_W:0][WORD_W-1:0] stage;

    assign stage[0] = in_word;

    for (genvar k = 0; k < PTR_W; k++) begin : g_stage
        localparam int SH = 1 << k;
        assign stage[k+1] = shamt[k]
            ? {stage[k][WORD_W-1-SH:0], stage[k][WORD_W-1:WORD_W-SH]}
            : stage[k];
    end

    assign out_word = stage[PTR_W];

endmodule

// File: rtl/bitstream_aligner.sv
// Two-word buffer presenting the next 64 unconsumed stream bits as an aligned window.
// The decoder consumes 1..64 bits per cycle; crossing a word boundary retires cur.
module bitstream_aligner
    import rice_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    input  logic              flush,
    output logic              win_valid,
    output logic [WORD_W-1:0] win_data,
    input  logic              cons_valid,
    input  logic [CONS_W-1:0] cons_bits,
    output logic [1:0]        level,
    output logic              err
);

    aligner_state_e    state_q, state_d;
    logic [WORD_W-1:0] cur_q, cur_d;
    logic [WORD_W-1:0] nxt_q, nxt_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              err_q, err_d;

    logic              accept;
    logic              consume_req;
    logic [CONS_W-1:0] sum;
    logic [WORD_W-1:0] rot_cur;
    logic [WORD_W-1:0] rot_nxt;
    logic [WORD_W-1:0] keep_mask;

    // Outputs decode from registered state only, never from inputs.
    assign in_ready  = (state_q != ST_FULL);
    assign win_valid = (state_q == ST_FULL);
    assign level     = state_q;
    assign err       = err_q;

    assign accept      = in_valid & in_ready;
    assign consume_req = cons_valid & win_valid;
    assign sum         = CONS_W'(ptr_q) + cons_bits;

    // NOTE: every always_comb output is defaulted to its held value first so
    // no path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        ptr_d   = ptr_q;
        err_d   = err_q;

        if (flush) begin
            state_d = ST_EMPTY;
            ptr_d   = '0;
        end else if (accept) begin
            case (state_q)
                ST_EMPTY: begin
                    cur_d   = in_data;
                    state_d = ST_HALF;
                end
                ST_HALF: begin
                    nxt_d   = in_data;
                    state_d = ST_FULL;
                end
                default: state_d = ST_EMPTY;
            endcase
        end else if (consume_req) begin
            if (cons_bits_legal(cons_bits)) begin
                ptr_d = sum[PTR_W-1:0];
                // sum tops out at 127, so bit 6 alone marks crossing into nxt.
                if (sum[PTR_W]) begin
                    cur_d   = nxt_q;
                    state_d = ST_HALF;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    // NOTE: the data words are reset too, because the window must read zero
    // straight out of reset, not just be flagged invalid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            cur_q   <= '0;
            nxt_q   <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    leftrotor u_rot_cur (
        .in_word  (cur_q),
        .shamt    (ptr_q),
        .out_word (rot_cur)
    );

    leftrotor u_rot_nxt (
        .in_word  (nxt_q),
        .shamt    (ptr_q),
        .out_word (rot_nxt)
    );

    // Upper bits come from what remains of cur, the low ptr bits from the head of nxt.
    assign keep_mask = {WORD_W{1'b1}} << ptr_q;
    assign win_data  = (rot_cur & keep_mask) | (rot_nxt & ~keep_mask);

endmodule
